// File: rtl/instr_mem_readout.sv
// -----------------------------------------------------------------------------
// instr_mem_readout
//   Steps through a packed instruction memory one entry at a time, driven by
//   a raw push button. The first press takes a snapshot of instrMem and shows
//   entry 0. Each later press shows the next entry. A press after the last
//   entry enters DONE, and one more press returns to IDLE.
//
//   Optional feature: define DEBOUNCE_EN to debounce the synchronized button.
//   The level is accepted only after DEB_CYCLES consecutive equal samples.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   instrMem    in   N_INSTR*W packed entries, entry k at [k*W +: W]
//   but_out     in   raw asynchronous step button, active high
//   output_val  out  W-bit displayed instruction (registered)
//   out_idx     out  index of the displayed instruction (registered)
//   out_valid   out  high while output_val/out_idx hold a displayed entry
//   done        out  high after the last entry has been stepped past
// -----------------------------------------------------------------------------
module instr_mem_readout #(
    parameter int N_INSTR    = 8,
    parameter int W          = 8,
    parameter int DEB_CYCLES = 16,
    localparam int IW        = (N_INSTR > 1) ? $clog2(N_INSTR) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_INSTR*W-1:0] instrMem,
    input  logic                 but_out,
    output logic [W-1:0]         output_val,
    output logic [IW-1:0]        out_idx,
    output logic                 out_valid,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

    // ---------------- button conditioning ----------------
    logic sync1_q, sync2_q;
    logic started_q, arm_q, prev_q;
    logic level;
    logic press;

    // The synchronizer resets to 0, so a button held through reset release
    // would look like a fresh rising edge. arm_q blocks presses until the
    // button has been seen low after reset. started_q skips the first cycle,
    // when the flops still hold their reset zeros. After that first cycle,
    // sync1_q holds a real sample of the button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            started_q <= 1'b0;
            arm_q     <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            sync1_q   <= but_out;
            sync2_q   <= sync1_q;
            started_q <= 1'b1;
            if (started_q && !sync1_q && !level)
                arm_q <= 1'b1;
            prev_q    <= level;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] deb_cnt_q;
    logic          deb_q;

    // The counter tracks how many samples in a row differ from the accepted
    // level. Any sample that equals the accepted level clears the count, so
    // a glitch shorter than DEB_CYCLES never changes deb_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
        end else if (sync2_q == deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_q     <= sync2_q;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + CW'(1);
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    // One-cycle pulse on the accepted 0->1 transition. The pulse is internal
    // only; every output below is a register.
    assign press = level & ~prev_q & arm_q;

    // ---------------- readout FSM ----------------
    state_t                      state_q, state_d;
    logic [N_INSTR-1:0][W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]                val_q, val_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;
    logic [IW-1:0]               idx_nxt;

    assign idx_nxt = idx_q + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            val_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            val_q    <= val_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        val_d    = val_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        done_d   = done_q;
        if (press) begin
            unique case (state_q)
                IDLE: begin
                    shadow_d = instrMem;
                    val_d    = instrMem[W-1:0];
                    idx_d    = '0;
                    valid_d  = 1'b1;
                    done_d   = 1'b0;
                    state_d  = SHOW;
                end
                SHOW: begin
                    if (idx_q != IW'(N_INSTR - 1)) begin
                        // Read from the snapshot, never from the live input.
                        idx_d = idx_nxt;
                        val_d = shadow_q[idx_nxt];
                    end else begin
                        val_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    val_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign output_val = val_q;
    assign out_idx    = idx_q;
    assign out_valid  = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_instr_mem_readout.sv
module tb_instr_mem_readout;

    localparam int N_INSTR = 8;
    localparam int W       = 8;
    localparam int DEB     = 16;
`ifdef DEBOUNCE_EN
    localparam int LAT  = 3 + DEB;
    localparam int HOLD = 40;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 4;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_INSTR*W-1:0] instrMem = '0;
    logic                 but_out = 1'b0;
    logic [W-1:0]         output_val;
    logic [2:0]           out_idx;
    logic                 out_valid;
    logic                 done;

    int errors = 0;
    int checks = 0;

    logic [63:0] data  = 64'hFF89A8908C8A8988;
    logic [63:0] data2 = 64'h0102030405060A5A;
    logic [7:0]  exp_v [8] = '{8'h88, 8'h89, 8'h8A, 8'h8C, 8'h90, 8'hA8, 8'h89, 8'hFF};

    always #5 clk = ~clk;

    instr_mem_readout #(.N_INSTR(N_INSTR), .W(W), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .instrMem(instrMem), .but_out(but_out),
        .output_val(output_val), .out_idx(out_idx), .out_valid(out_valid), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] v, input logic [2:0] i,
                             input logic vl, input logic d);
        check({tag, ".val"},   64'(output_val), 64'(v));
        check({tag, ".idx"},   64'(out_idx),    64'(i));
        check({tag, ".valid"}, 64'(out_valid),  64'(vl));
        check({tag, ".done"},  64'(done),       64'(d));
    endtask

    task automatic press();
        @(negedge clk) but_out = 1'b1;
        repeat (HOLD) @(negedge clk);
        but_out = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        instrMem = data;
        #1;
        check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Latency of the first press, then keep holding (one step only).
        but_out = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 check("lat_before", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 check_out("first", 8'h88, 3'd0, 1'b1, 1'b0);
        repeat (200) @(posedge clk);
        #1 check_out("held200", 8'h88, 3'd0, 1'b1, 1'b0);
        @(negedge clk) but_out = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("release", 64'(out_idx), 64'd0);

        // Live input cleared: the snapshot must still drive the display.
        instrMem = '0;
        for (int k = 1; k < 8; k++) begin
            press();
            check($sformatf("step%0d.val", k), 64'(output_val), 64'(exp_v[k]));
            check($sformatf("step%0d.idx", k), 64'(out_idx), 64'(k));
        end
        check("last.valid", 64'(out_valid), 64'd1);
        press();
        check_out("done", 8'h00, 3'd0, 1'b0, 1'b1);
        press();
        check_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Restart takes a fresh snapshot.
        instrMem = data2;
        press();
        check_out("restart", 8'h5A, 3'd0, 1'b1, 1'b0);
        press();
        press();
        check("pre_rst.idx", 64'(out_idx), 64'd2);

        // Asynchronous reset in the middle of a clock cycle.
        #2 rst_n = 1'b0;
        #1 check_out("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        instrMem = data;
        repeat (4) @(negedge clk);
        press();
        check_out("post_rst", 8'h88, 3'd0, 1'b1, 1'b0);

        // Button held through reset release must not generate a press.
        @(negedge clk) but_out = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (HOLD + 20) @(negedge clk);
        check_out("held_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        but_out = 1'b0;
        repeat (HOLD + 5) @(negedge clk);
        check("held_rst_rel", 64'(out_valid), 64'd0);
        press();
        check_out("after_held", 8'h88, 3'd0, 1'b1, 1'b0);

`ifdef DEBOUNCE_EN
        // A short glitch is filtered out.
        @(negedge clk) but_out = 1'b1;
        repeat (5) @(negedge clk);
        but_out = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch.idx", 64'(out_idx), 64'd0);
        // A long press steps once, DEB cycles later than the plain path.
        but_out = 1'b1;
        repeat (2 + DEB) @(posedge clk);
        #1 check("deb_before", 64'(out_idx), 64'd0);
        @(posedge clk);
        #1 check("deb_at.idx", 64'(out_idx), 64'd1);
        check("deb_at.val", 64'(output_val), 64'h89);
        repeat (20) @(negedge clk);
        but_out = 1'b0;
        repeat (40) @(negedge clk);
        check("deb_one", 64'(out_idx), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_readout.md
INSTR_MEM_READOUT -- requirements
Module: instr_mem_readout

Interface
REQ-001 Parameter N_INSTR, default 8, SHALL set the number of instruction entries to read out.
REQ-002 Parameter W, default 8, SHALL set the width of each instruction in bits.
REQ-003 Parameter DEB_CYCLES, default 16, SHALL set the debounce stable-count (used only with DEBOUNCE_EN).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 instrMem  input  N_INSTR*W  SHALL carry packed instructions; entry k at bits [k*W+W-1:k*W]; entry 0 is the first loaded.
REQ-007 but_out  input  1  SHALL be the raw, asynchronous, active-high step button.
REQ-008 output_val  output  W  SHALL present the currently displayed instruction.
REQ-009 out_idx  output  clog2(N_INSTR)  SHALL present the index of the displayed instruction.
REQ-010 out_valid  output  1  SHALL be high while output_val/out_idx hold a displayed entry.
REQ-011 done  output  1  SHALL be high after the last entry has been stepped past.

Function
REQ-012 but_out SHALL pass through a 2-flop synchronizer; a press event SHALL be a one-cycle pulse on the synchronized (and, if enabled, debounced) level's 0->1 transition.
REQ-013 Without debounce, outputs SHALL update on the 3rd rising clk edge after but_out rises (setup met).
REQ-014 A held button SHALL produce exactly one press event; release SHALL produce none.
REQ-015 FSM states SHALL be IDLE, SHOW, DONE; reset state IDLE.
REQ-016 IDLE: output_val=0, out_idx=0, out_valid=0, done=0.
REQ-017 IDLE + press: SHALL copy instrMem into an internal shadow register, show entry 0 (out_idx=0, out_valid=1), go to SHOW.
REQ-018 SHOW + press with out_idx<N_INSTR-1: SHALL increment out_idx and show the shadow entry at the new index.
REQ-019 SHOW + press with out_idx=N_INSTR-1: SHALL go to DONE with out_valid=0, done=1, output_val=0, out_idx=0.
REQ-020 DONE + press: SHALL go to IDLE (done=0); the next press restarts at entry 0 with a fresh snapshot.
REQ-021 Changes to instrMem while in SHOW or DONE SHALL NOT affect output_val.
REQ-022 out_idx SHALL never exceed N_INSTR-1; no wrap occurs inside SHOW.
REQ-023 All outputs SHALL be driven directly from registers (no combinational paths from inputs).

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, all outputs 0, shadow register 0, synchronizer and debounce state 0.
REQ-025 Reset asserted mid-SHOW SHALL abandon the readout; after release the next press starts at entry 0.
REQ-026 A button held through reset release SHALL NOT generate a press until released and pressed again.

Configuration
REQ-027 Macro DEBOUNCE_EN defined: synchronized button level SHALL be accepted only after DEB_CYCLES consecutive equal samples; press latency grows by DEB_CYCLES cycles; shorter glitches SHALL be ignored.
REQ-028 Macro DEBOUNCE_EN undefined: no debounce counter SHALL be built; the synchronized level feeds the edge detector directly (REQ-013).

Verification
REQ-029 instrMem={FF,89,A8,90,8C,8A,89,88}h, one press -> output_val=88h, out_idx=0, out_valid=1, done=0.
REQ-030 Same data, 8 presses -> last shows output_val=FFh, out_idx=7; 9th press -> out_valid=0, done=1; 10th -> IDLE, all outputs 0.
REQ-031 One press, then instrMem changed to all 00h, second press -> output_val=89h, out_idx=1 (snapshot kept).
REQ-032 but_out held high 200 cycles -> exactly one step (out_idx stays 0).
REQ-033 Three presses (out_idx=2), rst_n pulsed low mid-cycle -> outputs 0 immediately, state IDLE; next press -> out_idx=0, output_val=88h.
REQ-034 DEBOUNCE_EN defined, DEB_CYCLES=16: 5-cycle button glitch -> no change; 40-cycle press -> one step, update 16 cycles later than REQ-013 timing.
